alu_stage: RTL and testbench

- Registered, parametrised ALU execute stage with a valid/ready handshake on both sides, replacing the purely combinational ALU wrapper.
- Carries a static sideband field (destination register address plus write-enable bit) alongside each operation, aligned with its result.
- Single-cycle ops complete in 1 clock. Optional iterative multiply takes OPERAND_SIZE+1 clocks.
- Sits between decode/register-read and writeback in the processor pipeline.

---
 rtl/alu_stage.sv | 143 ++++++++++++++
 tb/tb_alu_stage.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_stage.sv
// rtl/alu_stage.sv - registered ALU execute stage with valid/ready handshakes and sideband
// Optional iterative shift-add multiplier for opcode 10 enabled by defining ALU_MUL_EN.
module alu_stage #(
  parameter int OPERAND_SIZE     = 32,
  parameter int REG_ADDRESS_SIZE = 5,
  parameter int OP_SIZE          = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        ALU_in_valid,
  output logic                        ALU_in_ready,
  input  logic [OP_SIZE-1:0]          ALU_op,
  input  logic [OPERAND_SIZE-1:0]     ALU_operand1,
  input  logic [OPERAND_SIZE-1:0]     ALU_operand2,
  input  logic [REG_ADDRESS_SIZE:0]   ALU_static_in,
  output logic                        ALU_out_valid,
  input  logic                        ALU_out_ready,
  output logic [OPERAND_SIZE-1:0]     ALU_result,
  output logic                        ALU_zero,
  output logic                        ALU_illegal,
  output logic [REG_ADDRESS_SIZE:0]   ALU_static_out
);

  localparam int SH = $clog2(OPERAND_SIZE);

  localparam logic [OP_SIZE-1:0] OP_ADD  = OP_SIZE'(0);
  localparam logic [OP_SIZE-1:0] OP_SUB  = OP_SIZE'(1);
  localparam logic [OP_SIZE-1:0] OP_AND  = OP_SIZE'(2);
  localparam logic [OP_SIZE-1:0] OP_OR   = OP_SIZE'(3);
  localparam logic [OP_SIZE-1:0] OP_XOR  = OP_SIZE'(4);
  localparam logic [OP_SIZE-1:0] OP_SLT  = OP_SIZE'(5);
  localparam logic [OP_SIZE-1:0] OP_SLTU = OP_SIZE'(6);
  localparam logic [OP_SIZE-1:0] OP_SLL  = OP_SIZE'(7);
  localparam logic [OP_SIZE-1:0] OP_SRL  = OP_SIZE'(8);
  localparam logic [OP_SIZE-1:0] OP_SRA  = OP_SIZE'(9);
`ifdef ALU_MUL_EN
  localparam logic [OP_SIZE-1:0] OP_MUL  = OP_SIZE'(10);
`endif

  logic [SH-1:0]                  shamt;
  logic signed [OPERAND_SIZE-1:0] sra_res;
  logic [OPERAND_SIZE-1:0]        comb_result;
  logic                           comb_illegal;
  logic                           accept;

  assign shamt   = ALU_operand2[SH-1:0];
  assign sra_res = $signed(ALU_operand1) >>> shamt;
  assign accept  = ALU_in_valid && ALU_in_ready;

  // MUL decodes as illegal here; when the multiplier is present the accept path diverts it.
  always_comb begin
    comb_result  = '0;
    comb_illegal = 1'b0;
    case (ALU_op)
      OP_ADD:  comb_result = ALU_operand1 + ALU_operand2;
      OP_SUB:  comb_result = ALU_operand1 - ALU_operand2;
      OP_AND:  comb_result = ALU_operand1 & ALU_operand2;
      OP_OR:   comb_result = ALU_operand1 | ALU_operand2;
      OP_XOR:  comb_result = ALU_operand1 ^ ALU_operand2;
      OP_SLT:  comb_result = {{(OPERAND_SIZE-1){1'b0}}, $signed(ALU_operand1) < $signed(ALU_operand2)};
      OP_SLTU: comb_result = {{(OPERAND_SIZE-1){1'b0}}, ALU_operand1 < ALU_operand2};
      OP_SLL:  comb_result = ALU_operand1 << shamt;
      OP_SRL:  comb_result = ALU_operand1 >> shamt;
      OP_SRA:  comb_result = sra_res;
      default: comb_illegal = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t                  state;
  logic [SH-1:0]           step_cnt;
  logic [OPERAND_SIZE-1:0] mul_a;
  logic [OPERAND_SIZE-1:0] mul_b;
  logic [OPERAND_SIZE-1:0] mul_acc;
  logic [OPERAND_SIZE-1:0] mul_acc_next;
  logic [REG_ADDRESS_SIZE:0] mul_static;

  assign mul_acc_next = mul_acc + (mul_b[0] ? mul_a : '0);
  assign ALU_in_ready = (state == IDLE) && (!ALU_out_valid || ALU_out_ready);
`else
  assign ALU_in_ready = !ALU_out_valid || ALU_out_ready;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ALU_out_valid  <= 1'b0;
      ALU_result     <= '0;
      ALU_zero       <= 1'b0;
      ALU_illegal    <= 1'b0;
      ALU_static_out <= '0;
`ifdef ALU_MUL_EN
      state      <= IDLE;
      step_cnt   <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_acc    <= '0;
      mul_static <= '0;
`endif
    end else begin
      if (ALU_out_valid && ALU_out_ready) begin
        ALU_out_valid <= 1'b0;
      end
`ifdef ALU_MUL_EN
      if (accept && ALU_op == OP_MUL) begin
        state      <= MUL_BUSY;
        step_cnt   <= '0;
        mul_a      <= ALU_operand1;
        mul_b      <= ALU_operand2;
        mul_acc    <= '0;
        mul_static <= ALU_static_in;
      end else
`endif
      if (accept) begin
        ALU_out_valid  <= 1'b1;
        ALU_result     <= comb_result;
        ALU_zero       <= (comb_result == '0);
        ALU_illegal    <= comb_illegal;
        ALU_static_out <= ALU_static_in;
      end
`ifdef ALU_MUL_EN
      // One partial product per cycle; the last step writes straight into the output slot.
      if (state == MUL_BUSY) begin
        mul_acc <= mul_acc_next;
        mul_a   <= mul_a << 1;
        mul_b   <= mul_b >> 1;
        if (step_cnt == SH'(OPERAND_SIZE-1)) begin
          state          <= IDLE;
          ALU_out_valid  <= 1'b1;
          ALU_result     <= mul_acc_next;
          ALU_zero       <= (mul_acc_next == '0);
          ALU_illegal    <= 1'b0;
          ALU_static_out <= mul_static;
        end else begin
          step_cnt <= step_cnt + SH'(1);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_stage.sv
// tb/tb_alu_stage.sv - self-checking bench for alu_stage against a behavioural model
// Covers the ALU_MUL_EN build and the default build.
module tb_alu_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ALU_in_valid;
  logic        ALU_in_ready;
  logic [3:0]  ALU_op;
  logic [31:0] ALU_operand1;
  logic [31:0] ALU_operand2;
  logic [5:0]  ALU_static_in;
  logic        ALU_out_valid;
  logic        ALU_out_ready;
  logic [31:0] ALU_result;
  logic        ALU_zero;
  logic        ALU_illegal;
  logic [5:0]  ALU_static_out;
  logic [39:0] got;

  int pass_cnt = 0;
  int total_cnt = 0;

  alu_stage #(.OPERAND_SIZE(32), .REG_ADDRESS_SIZE(5), .OP_SIZE(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .ALU_in_valid(ALU_in_valid), .ALU_in_ready(ALU_in_ready),
    .ALU_op(ALU_op), .ALU_operand1(ALU_operand1), .ALU_operand2(ALU_operand2),
    .ALU_static_in(ALU_static_in),
    .ALU_out_valid(ALU_out_valid), .ALU_out_ready(ALU_out_ready),
    .ALU_result(ALU_result), .ALU_zero(ALU_zero), .ALU_illegal(ALU_illegal),
    .ALU_static_out(ALU_static_out)
  );

  always #5 clk = ~clk;

  assign got = {ALU_illegal, ALU_zero, ALU_result, ALU_static_out};

  // Returns {illegal, zero, result, sideband}.
  function automatic logic [39:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [5:0] st);
    logic [31:0] r;
    logic        ill;
    logic [63:0] p;
    int          sh;
    r   = 32'd0;
    ill = 1'b0;
    p   = 64'd0;
    sh  = int'(b[4:0]);
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd6: r = (a < b) ? 32'd1 : 32'd0;
      4'd7: r = a << sh;
      4'd8: r = a >> sh;
      4'd9: r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      4'd10: begin
`ifdef ALU_MUL_EN
        p = {32'h0, a} * {32'h0, b};
        r = p[31:0];
`else
        ill = 1'b1;
`endif
      end
      default: ill = 1'b1;
    endcase
    return {ill, (r == 32'd0), r, st};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] st);
    ALU_in_valid  = 1'b1;
    ALU_op        = op;
    ALU_operand1  = a;
    ALU_operand2  = b;
    ALU_static_in = st;
  endtask

  task automatic test_reset();
    drive(4'd0, 32'd3, 32'd4, 6'h15);
    ALU_out_ready = 1'b0;
    tick();
    ALU_in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if ({ALU_out_valid, got} !== 41'd0)
      $display("FAIL reset_outputs got=%h exp=0", {ALU_out_valid, got});
    else pass_cnt++;
    tick();
    reset_n = 1'b1;
    #1;
    total_cnt++;
    if (ALU_in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", ALU_in_ready);
    else pass_cnt++;
  endtask

  task automatic test_add();
    ALU_out_ready = 1'b1;
    drive(4'd0, 32'hFFFF_FFFF, 32'd1, 6'h25);
    #1;
    tick();
    ALU_in_valid = 1'b0;
    total_cnt++;
    if ({ALU_out_valid, got} !== {1'b1, 1'b0, 1'b1, 32'h0, 6'h25})
      $display("FAIL add_wrap got=%h exp=%h", {ALU_out_valid, got}, {1'b1, 1'b0, 1'b1, 32'h0, 6'h25});
    else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [3] = '{4'd1, 4'd5, 4'd9};
    logic [31:0] as  [3] = '{32'd5, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] bs  [3] = '{32'd7, 32'd1, 32'd4};
    logic [31:0] exp [3] = '{32'hFFFF_FFFE, 32'h1, 32'hF800_0000};
    ALU_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(ops[i], as[i], bs[i], 6'(i + 1));
      #1;
      total_cnt++;
      if (ALU_in_ready !== 1'b1) $display("FAIL b2b_ready[%0d] got=%b exp=1", i, ALU_in_ready);
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({ALU_out_valid, ALU_result, ALU_static_out} !== {1'b1, exp[i], 6'(i + 1)})
        $display("FAIL b2b_result[%0d] got=%h exp=%h", i,
                 {ALU_out_valid, ALU_result, ALU_static_out}, {1'b1, exp[i], 6'(i + 1)});
      else pass_cnt++;
    end
    ALU_in_valid = 1'b0;
    tick();
    total_cnt++;
    if (ALU_out_valid !== 1'b0) $display("FAIL b2b_valid_drop got=%b exp=0", ALU_out_valid);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [39:0] exp_x;
    logic [39:0] exp_n;
    exp_x = model(4'd4, 32'hF0F0_1234, 32'h0FF0_FFFF, 6'h11);
    exp_n = model(4'd2, 32'hDEAD_BEEF, 32'h0000_FFFF, 6'h22);
    ALU_out_ready = 1'b0;
    drive(4'd4, 32'hF0F0_1234, 32'h0FF0_FFFF, 6'h11);
    tick();
    drive(4'd2, 32'hDEAD_BEEF, 32'h0000_FFFF, 6'h22);
    for (int j = 0; j < 3; j++) begin
      #1;
      total_cnt++;
      if ({ALU_in_ready, ALU_out_valid, got} !== {1'b0, 1'b1, exp_x})
        $display("FAIL stall[%0d] got=%h exp=%h", j, {ALU_in_ready, ALU_out_valid, got}, {1'b0, 1'b1, exp_x});
      else pass_cnt++;
      tick();
    end
    ALU_out_ready = 1'b1;
    #1;
    total_cnt++;
    if (ALU_in_ready !== 1'b1) $display("FAIL stall_release_ready got=%b exp=1", ALU_in_ready);
    else pass_cnt++;
    tick();
    ALU_in_valid = 1'b0;
    total_cnt++;
    if ({ALU_out_valid, got} !== {1'b1, exp_n})
      $display("FAIL stall_next got=%h exp=%h", {ALU_out_valid, got}, {1'b1, exp_n});
    else pass_cnt++;
    tick();
  endtask

  task automatic test_illegal();
    ALU_out_ready = 1'b1;
    drive(4'd15, $urandom, $urandom, 6'h3F);
    tick();
    ALU_in_valid = 1'b0;
    total_cnt++;
    if ({ALU_out_valid, got} !== {1'b1, 1'b1, 1'b1, 32'h0, 6'h3F})
      $display("FAIL illegal got=%h exp=%h", {ALU_out_valid, got}, {1'b1, 1'b1, 1'b1, 32'h0, 6'h3F});
    else pass_cnt++;
    tick();
  endtask

`ifdef ALU_MUL_EN
  task automatic test_mul();
    int   lat;
    logic ready_bad;
    logic valid_seen;
    ALU_out_ready = 1'b1;
    drive(4'd10, 32'h0001_0003, 32'h0002_0005, 6'h0A);
    #1;
    total_cnt++;
    if (ALU_in_ready !== 1'b1) $display("FAIL mul_accept_ready got=%b exp=1", ALU_in_ready);
    else pass_cnt++;
    tick();
    lat = 1;
    ready_bad = 1'b0;
    drive(4'd0, $urandom, $urandom, 6'h01);
    while (!ALU_out_valid && lat < 100) begin
      if (ALU_in_ready !== 1'b0) ready_bad = 1'b1;
      ALU_operand1 = $urandom;
      tick();
      lat++;
    end
    ALU_in_valid = 1'b0;
    total_cnt++;
    if (ready_bad) $display("FAIL mul_busy_ready got=1 exp=0");
    else pass_cnt++;
    total_cnt++;
    if (lat != 33) $display("FAIL mul_latency got=%0d exp=33", lat);
    else pass_cnt++;
    total_cnt++;
    if (got !== {1'b0, 1'b0, 32'h000B_000F, 6'h0A})
      $display("FAIL mul_result got=%h exp=%h", got, {1'b0, 1'b0, 32'h000B_000F, 6'h0A});
    else pass_cnt++;
    tick();
    drive(4'd10, 32'h0001_0003, 32'h0002_0005, 6'h0B);
    tick();
    ALU_in_valid = 1'b0;
    repeat (9) tick();
    reset_n = 1'b0;
    #1;
    tick();
    reset_n = 1'b1;
    valid_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (ALU_out_valid) valid_seen = 1'b1;
      tick();
    end
    total_cnt++;
    if (valid_seen || ALU_in_ready !== 1'b1)
      $display("FAIL mul_reset_abort valid_seen=%b in_ready=%b exp=0/1", valid_seen, ALU_in_ready);
    else pass_cnt++;
  endtask
`else
  task automatic test_mul_disabled();
    ALU_out_ready = 1'b1;
    drive(4'd10, 32'h0001_0003, 32'h0002_0005, 6'h0C);
    tick();
    ALU_in_valid = 1'b0;
    total_cnt++;
    if ({ALU_out_valid, got} !== {1'b1, 1'b1, 1'b1, 32'h0, 6'h0C})
      $display("FAIL mul_disabled got=%h exp=%h", {ALU_out_valid, got}, {1'b1, 1'b1, 1'b1, 32'h0, 6'h0C});
    else pass_cnt++;
    tick();
  endtask
`endif

  task automatic test_random();
    logic [39:0] exp_q [$];
    logic [39:0] e;
    int sent;
    int cyc;
    sent = 0;
    cyc = 0;
    while ((sent < 40 || exp_q.size() > 0) && cyc < 3000) begin
      if (sent < 40) begin
        drive(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom,
              ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom, 6'($urandom));
        ALU_in_valid = ($urandom_range(0, 3) != 0);
        ALU_out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        ALU_in_valid = 1'b0;
        ALU_out_ready = 1'b1;
      end
      #1;
      if (ALU_out_valid && ALU_out_ready) begin
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL rand_unexpected got=%h exp=none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) $display("FAIL rand_result got=%h exp=%h", got, e);
          else pass_cnt++;
        end
      end
      if (ALU_in_valid && ALU_in_ready) begin
        exp_q.push_back(model(ALU_op, ALU_operand1, ALU_operand2, ALU_static_in));
        sent++;
      end
      tick();
      cyc++;
    end
    ALU_in_valid = 1'b0;
    total_cnt++;
    if (exp_q.size() != 0 || sent != 40)
      $display("FAIL rand_drain pending=%0d sent=%0d exp=0/40", exp_q.size(), sent);
    else pass_cnt++;
  endtask

  initial begin
    reset_n       = 1'b0;
    ALU_in_valid  = 1'b0;
    ALU_op        = 4'd0;
    ALU_operand1  = 32'd0;
    ALU_operand2  = 32'd0;
    ALU_static_in = 6'd0;
    ALU_out_ready = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    test_reset();
    test_add();
    test_back_to_back();
    test_backpressure();
    test_illegal();
`ifdef ALU_MUL_EN
    test_mul();
`else
    test_mul_disabled();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
